// File: rtl/term_ctrl.sv
// Character terminal controller: cursor tracking, text writes and row/screen clears into a VRAM A-port.
// Define TERM_SCROLL_EN to scroll on a line feed at the bottom row instead of wrapping to row 0.
module term_ctrl #(
  parameter int unsigned COLS = 60,
  parameter int unsigned ROWS = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [10:0] o_vram_addr,
  output logic [7:0]  o_vram_din,
  input  logic [7:0]  i_vram_dout,
  output logic        o_vram_ce,
  output logic        o_vram_wre,
  output logic        o_busy
);

  localparam int unsigned XW = 6;
  localparam int unsigned YW = 5;
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
  localparam logic [7:0]    SPACE  = 8'h20;

  typedef enum logic [2:0] {IDLE, PUT, CLR, RD, WR} state_t;

  state_t        state, state_n;
  logic [XW-1:0] cur_x, cur_x_n, cx, cx_n;
  logic [YW-1:0] cur_y, cur_y_n, cy, cy_n, clr_end, clr_end_n;
  logic [7:0]    data, data_n;
  logic          put_adv, put_adv_n;
  logic          do_nl;

  logic          ready_n, busy_n, ce_n, wre_n;
  logic [10:0]   addr_n;
  logic [7:0]    din_n, din_q;

  // Next-state and cursor/counter update
  always_comb begin
    state_n   = state;
    cur_x_n   = cur_x;
    cur_y_n   = cur_y;
    cx_n      = cx;
    cy_n      = cy;
    clr_end_n = clr_end;
    data_n    = data;
    put_adv_n = put_adv;
    do_nl     = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if (i_data >= 8'h20 && i_data <= 8'h7E) begin
            state_n   = PUT;
            data_n    = i_data;
            put_adv_n = 1'b1;
          end else begin
            case (i_data)
              8'h0D: cur_x_n = '0;
              8'h0A: do_nl = 1'b1;
              8'h08: begin
                if (cur_x != '0) begin
                  cur_x_n   = cur_x - 6'd1;
                  data_n    = SPACE;
                  put_adv_n = 1'b0;
                  state_n   = PUT;
                end
              end
              8'h0C: begin
                cur_x_n   = '0;
                cur_y_n   = '0;
                cx_n      = '0;
                cy_n      = '0;
                clr_end_n = Y_LAST;
                state_n   = CLR;
              end
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        if (!put_adv) begin
          state_n = IDLE;
        end else if (cur_x == X_LAST) begin
          cur_x_n = '0;
          do_nl   = 1'b1;
        end else begin
          cur_x_n = cur_x + 6'd1;
          state_n = IDLE;
        end
      end
      CLR: begin
        if (cx == X_LAST) begin
          cx_n = '0;
          if (cy == clr_end) state_n = IDLE;
          else               cy_n    = cy + 5'd1;
        end else begin
          cx_n = cx + 6'd1;
        end
      end
`ifdef TERM_SCROLL_EN
      RD: state_n = WR;
      WR: begin
        if (cx == X_LAST) begin
          cx_n = '0;
          if (cy == Y_LAST - 5'd1) begin
            cy_n      = Y_LAST;
            clr_end_n = Y_LAST;
            state_n   = CLR;
          end else begin
            cy_n    = cy + 5'd1;
            state_n = RD;
          end
        end else begin
          cx_n    = cx + 6'd1;
          state_n = RD;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    // New-line action shared by LF and auto-wrap
    if (do_nl) begin
      cx_n = '0;
      if (cur_y != Y_LAST) begin
        cur_y_n   = cur_y + 5'd1;
        cy_n      = cur_y + 5'd1;
        clr_end_n = cur_y + 5'd1;
        state_n   = CLR;
      end else begin
`ifdef TERM_SCROLL_EN
        cy_n    = '0;
        state_n = RD;
`else
        cur_y_n   = '0;
        cy_n      = '0;
        clr_end_n = '0;
        state_n   = CLR;
`endif
      end
    end
  end

  // Port values for the upcoming state, registered below
  always_comb begin
    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
    ce_n    = (state_n != IDLE);
    wre_n   = (state_n != IDLE) && (state_n != RD);
    case (state_n)
      CLR, WR: addr_n = {cy_n, cx_n};
      RD:      addr_n = {cy_n + 5'd1, cx_n};
      default: addr_n = {cur_y_n, cur_x_n};
    endcase
    case (state_n)
      PUT:     din_n = data_n;
      CLR:     din_n = SPACE;
      default: din_n = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cur_x       <= '0;
      cur_y       <= '0;
      cx          <= '0;
      cy          <= '0;
      clr_end     <= '0;
      data        <= '0;
      put_adv     <= 1'b0;
      o_ready     <= 1'b0;
      o_busy      <= 1'b0;
      o_vram_ce   <= 1'b0;
      o_vram_wre  <= 1'b0;
      o_vram_addr <= '0;
      din_q       <= '0;
    end else begin
      state       <= state_n;
      cur_x       <= cur_x_n;
      cur_y       <= cur_y_n;
      cx          <= cx_n;
      cy          <= cy_n;
      clr_end     <= clr_end_n;
      data        <= data_n;
      put_adv     <= put_adv_n;
      o_ready     <= ready_n;
      o_busy      <= busy_n;
      o_vram_ce   <= ce_n;
      o_vram_wre  <= wre_n;
      o_vram_addr <= addr_n;
      din_q       <= din_n;
    end
  end

`ifdef TERM_SCROLL_EN
  // Copy data only exists the cycle after the read strobe, so it bypasses the register
  assign o_vram_din = (state == WR) ? i_vram_dout : din_q;
`else
  logic unused_dout;
  assign unused_dout = ^i_vram_dout;
  assign o_vram_din  = din_q;
`endif

endmodule

// File: tb/tb_term_ctrl.sv
// Directed self-checking bench for term_ctrl with a VRAM model; follows TERM_SCROLL_EN when defined.
module tb_term_ctrl;

  localparam int unsigned COLS = 60;
  localparam int unsigned ROWS = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  data;
  logic        ready;
  logic [10:0] addr;
  logic [7:0]  din;
  logic [7:0]  vram_dout;
  logic        ce;
  logic        wre;
  logic        busy;

  always #5 clk = ~clk;

  term_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (data),
    .i_valid     (valid),
    .o_ready     (ready),
    .o_vram_addr (addr),
    .o_vram_din  (din),
    .i_vram_dout (vram_dout),
    .o_vram_ce   (ce),
    .o_vram_wre  (wre),
    .o_busy      (busy)
  );

  // VRAM model: read data appears the cycle after the read strobe
  logic [7:0]  mem [0:2047];
  logic        pre_en;
  logic [10:0] pre_addr;
  logic [7:0]  pre_val;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_val;
    else if (ce) begin
      if (wre) mem[addr] <= din;
      else     vram_dout <= mem[addr];
    end
  end

  // Strobe monitor, sampled on the falling edge
  logic [18:0] wq[$];
  int rd_tot = 0, busy_tot = 0, nrdy_tot = 0, ce_tot = 0;
  always @(negedge clk) begin
    if (ce && wre)  wq.push_back({addr, din});
    if (ce && !wre) rd_tot++;
    if (busy)       busy_tot++;
    if (!ready)     nrdy_tot++;
    if (ce)         ce_tot++;
  end

  int n_cmp = 0, n_err = 0;
  int w0, r0, b0, nr0, c0;
  int n_wr, n_sp, bad_x, n_rd, n_busy, n_nrdy;
  logic [10:0] a_first, a_last;
  logic [7:0]  d_first;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    w0 = wq.size(); r0 = rd_tot; b0 = busy_tot; nr0 = nrdy_tot;
  endtask

  task automatic scan();
    n_wr = wq.size() - w0; n_rd = rd_tot - r0; n_busy = busy_tot - b0; n_nrdy = nrdy_tot - nr0;
    n_sp = 0; bad_x = 0; a_first = '0; d_first = '0; a_last = '0;
    for (int i = w0; i < wq.size(); i++) begin
      if (wq[i][7:0] == 8'h20) n_sp++;
      if (wq[i][13:8] >= 6'(COLS)) bad_x++;
    end
    if (n_wr > 0) begin
      a_first = wq[w0][18:8];
      d_first = wq[w0][7:0];
      a_last  = wq[wq.size()-1][18:8];
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(ready), 1);
  endtask

  task automatic send(input logic [7:0] b);
    mark();
    data  = b;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    wait_idle("ready_after_byte");
    scan();
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] v);
    pre_addr = a; pre_val = v; pre_en = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid = 1'b0; data = 8'h00; pre_en = 1'b0; pre_addr = '0; pre_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 0);
    check("rst_ce",    32'(ce),    0);
    check("rst_wre",   32'(wre),   0);
    check("rst_din",   32'(din),   0);
    check("rst_busy",  32'(busy),  0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 1);
    check("post_rst_addr",  32'(addr),  0);

    // 'A' at (0,0)
    send(8'h41);
    check("A_nwr",   n_wr,         1);
    check("A_addr",  32'(a_first), 32'h000);
    check("A_din",   32'(d_first), 32'h41);
    check("A_idle",  32'(addr),    32'h001);
    check("A_nrdy",  n_nrdy,       1);

    // CR and ignored codes
    send(8'h0D);
    check("CR_nwr",  n_wr,      0);
    check("CR_idle", 32'(addr), 32'h000);
    send(8'h41);
    send(8'h07);
    check("BEL_nwr",  n_wr,      0);
    check("BEL_idle", 32'(addr), 32'h001);
    send(8'hFF);
    check("FF8_nwr",  n_wr,      0);
    check("FF8_idle", 32'(addr), 32'h001);
    send(8'h0D);

    // Auto-wrap from (59,3)
    repeat (3) send(8'h0A);
    check("LF3_idle", 32'(addr), 32'h0C0);
    repeat (59) send(8'h78);
    check("pos59_idle", 32'(addr), 32'h0FB);
    send(8'h42);
    check("wrap_nwr",   n_wr,         61);
    check("wrap_first", 32'(a_first), 32'h0FB);
    check("wrap_din",   32'(d_first), 32'h42);
    check("wrap_nsp",   n_sp,         60);
    check("wrap_last",  32'(a_last),  32'h13B);
    check("wrap_idle",  32'(addr),    32'h100);

    // Form feed
    send(8'h0C);
    check("FF_nwr",   n_wr,         1020);
    check("FF_nsp",   n_sp,         1020);
    check("FF_badx",  bad_x,        0);
    check("FF_busy",  n_busy,       1020);
    check("FF_first", 32'(a_first), 32'h000);
    check("FF_last",  32'(a_last),  32'h43B);
    check("FF_idle",  32'(addr),    32'h000);

    // Backspace at (5,2) and at x=0
    repeat (2) send(8'h0A);
    repeat (5) send(8'h62);
    send(8'h08);
    check("BS_nwr",  n_wr,         1);
    check("BS_addr", 32'(a_first), 32'h084);
    check("BS_din",  32'(d_first), 32'h20);
    check("BS_idle", 32'(addr),    32'h084);
    send(8'h0D);
    send(8'h08);
    check("BS0_nwr",  n_wr,      0);
    check("BS0_idle", 32'(addr), 32'h080);

    // Line feed on the bottom row
    repeat (14) send(8'h0A);
    check("row16_idle", 32'(addr), 32'h400);
    preload(11'h045, 8'h5A);
    preload(11'h405, 8'h51);
    send(8'h0A);
`ifdef TERM_SCROLL_EN
    check("scr_nrd",  n_rd,         960);
    check("scr_nwr",  n_wr,         1020);
    check("scr_busy", n_busy,       1980);
    check("scr_idle", 32'(addr),    32'h400);
    check("scr_copy", 32'(mem[11'h005]), 32'h5A);
    check("scr_clr",  32'(mem[11'h405]), 32'h20);
`else
    check("lf_nrd",   n_rd,         0);
    check("lf_nwr",   n_wr,         60);
    check("lf_nsp",   n_sp,         60);
    check("lf_first", 32'(a_first), 32'h000);
    check("lf_last",  32'(a_last),  32'h03B);
    check("lf_idle",  32'(addr),    32'h000);
    check("lf_keep",  32'(mem[11'h405]), 32'h51);
`endif

    // Reset in the middle of a screen clear
    send(8'h41);
    mark();
    data  = 8'h0C;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    scan();
    c0 = ce_tot;
    check("mid_partial", 32'(n_wr > 90 && n_wr < 110), 1);
    check("mid_ce",      32'(ce),    0);
    check("mid_busy",    32'(busy),  0);
    check("mid_ready",   32'(ready), 0);
    repeat (3) @(negedge clk);
    check("mid_ready_hold", 32'(ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_ready_rel", 32'(ready), 1);
    check("mid_idle",      32'(addr),  32'h000);
    repeat (5) @(negedge clk);
    check("mid_nostrobe", ce_tot - c0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
